dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Shares the single-port data RAM between two requesters:
  - the pipeline memory-access stage (CPU port, normally has priority);
  - a secondary master such as a loader or DMA (DMA port).
- Issues at most one RAM access per clk cycle and routes the 1-cycle-latency read data back to the requester that owns it.
- A starvation counter guarantees the DMA port forward progress by stalling the CPU for one cycle.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 16, RAM data width.
- MAX_WAIT, 8, consecutive denied DMA-request cycles before DMA is forced through (legal range 1..255).

Ports:
- clk  input  1  system clock; the RAM is clocked on the same edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request, valid this cycle.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_stall  output  1  CPU request not accepted this cycle; CPU holds its request and freezes the pipeline.
- cpu_rdata  output  DATA_W  read data returned to the CPU.
- cpu_rvalid  output  1  cpu_rdata valid this cycle.
- dma_req  input  1  DMA access request; held until granted.
- dma_we  input  1  1 = write, 0 = read.
- dma_addr  input  ADDR_W  DMA address.
- dma_wdata  input  DATA_W  DMA write data.
- dma_gnt  output  1  DMA request accepted this cycle.
- dma_rdata  output  DATA_W  read data returned to DMA.
- dma_rvalid  output  1  dma_rdata valid this cycle.
- ram_addr  output  ADDR_W  RAM address.
- ram_data  output  DATA_W  RAM write data.
- ram_wren  output  1  RAM write enable.
- ram_q  input  DATA_W  RAM read data, valid the cycle after the address.

Behaviour:
- Grant decision is combinational each cycle:
  - force = dma_req && (wait_cnt == MAX_WAIT).
  - If force: grant DMA.
  - Else if cpu_req: grant CPU.
  - Else if dma_req: grant DMA.
  - Else: no grant.
- Outputs from the grant decision:
  - cpu_stall = cpu_req && DMA granted.
  - dma_gnt = DMA granted.
  - cpu_stall and dma_gnt are never high with cpu_req low and dma_req low respectively.
- RAM port mux:
  - Driven by the granted requester's addr/wdata/we.
  - With no grant: ram_wren = 0, ram_addr = 0, ram_data = 0.
  - ram_wren is never high without a grant.
- wait_cnt (8 bit, registered):
  - Cleared when DMA is granted or dma_req is low.
  - Incremented when dma_req is high and not granted.
  - Saturates at MAX_WAIT.
- Read return (registered owner tag, 1-cycle latency):
  - rd_owner <= {CPU, DMA, NONE} according to the granted access when we = 0; NONE for writes and for no grant.
  - cpu_rvalid = (rd_owner == CPU); dma_rvalid = (rd_owner == DMA).
  - cpu_rdata and dma_rdata = ram_q while their rvalid is high; 0 otherwise.
- Back-to-back accesses are fully pipelined: a new grant is allowed in the cycle a previous read returns.
- Write-then-read to the same address in consecutive cycles returns the new data; the RAM has no bypass and none is needed.
- Simultaneous requests:
  - CPU wins unless force is true.
  - A forced DMA grant lasts exactly one cycle; wait_cnt returns to 0, so the CPU regains priority on the next cycle.
- Reset (synchronous, reset high at a clk edge):
  - wait_cnt = 0, rd_owner = NONE, so cpu_rvalid = dma_rvalid = 0.
  - A read granted in the cycle reset is asserted does not produce an rvalid.
  - While reset is high, no grant is made: ram_wren = 0, dma_gnt = 0, cpu_stall = 0.
- Changing DMA request fields while dma_req is high and not yet granted is a protocol violation; the arbiter uses whatever is present in the grant cycle.

Test Plan:
- Single CPU read: cpu_req=1, we=0, addr=0x0010 for one cycle with RAM[0x10]=0xBEEF -> ram_addr=0x0010 that cycle; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF, dma_rvalid=0.
- Idle CPU: dma_req=1 write addr=0x0020 data=0x1234 with cpu_req=0 -> dma_gnt=1 the same cycle, ram_wren=1; a later DMA read of 0x0020 returns 0x1234 with dma_rvalid one cycle after its grant.
- Starvation: cpu_req held high continuously and dma_req raised, MAX_WAIT=8 -> dma_gnt=0 for 8 cycles, dma_gnt=1 and cpu_stall=1 on the 9th cycle, then CPU granted again (cpu_stall=0) on the 10th.
- Interleaved reads: CPU read 0x0001 in cycle n, forced DMA read 0x0002 in cycle n+1 -> cpu_rvalid in n+1 with RAM[1], dma_rvalid in n+2 with RAM[2]; never both rvalids in one cycle.
- Reset mid-operation: grant a CPU read, assert reset in the following cycle -> cpu_rvalid=0 after the reset edge; wait_cnt=0, so a DMA request after reset waits the full MAX_WAIT cycles against a busy CPU.
- No requests: cpu_req=dma_req=0 for 5 cycles -> ram_wren=0, dma_gnt=0, cpu_stall=0, both rvalid=0 throughout.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port arbiter for the single-port data RAM: CPU has priority,
// DMA is forced through after MAX_WAIT denied cycles.
module dram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    owner_e     rd_owner_q, rd_owner_d;
    logic       force_dma;
    logic       gnt_cpu;
    logic       gnt_dma;

    // No grant at all while reset is high.
    always_comb begin
        force_dma = dma_req && (wait_cnt_q == WAIT_MAX);
        gnt_dma   = !reset && (force_dma || (!cpu_req && dma_req));
        gnt_cpu   = !reset && cpu_req && !force_dma;
    end

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        if (gnt_dma) begin
            ram_addr = dma_addr;
            ram_data = dma_wdata;
            ram_wren = dma_we;
        end else if (gnt_cpu) begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
            ram_wren = cpu_we;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req || gnt_dma) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (gnt_dma && !dma_we) begin
            rd_owner_d = OWN_DMA;
        end else if (gnt_cpu && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        cpu_stall  = cpu_req && gnt_dma;
        dma_gnt    = gnt_dma;
        cpu_rvalid = (rd_owner_q == OWN_CPU);
        dma_rvalid = (rd_owner_q == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? ram_q : '0;
        dma_rdata  = dma_rvalid ? ram_q : '0;
    end

endmodule
